// File: rtl/colour_track_pkg.sv
// colour_track_pkg: shared definitions for the colour centroid tracker.
//   - default widths / active-area sizes
//   - colour-select encoding (iSel)
//   - tracker FSM state type
//   - colour_match(): per-pixel dominance test, 9-bit arithmetic
package colour_track_pkg;

  localparam int unsigned H_ACT_DEF = 640;
  localparam int unsigned V_ACT_DEF = 480;
  localparam int unsigned SUM_W_DEF = 28;
  localparam int unsigned CNT_W_DEF = 19;

  typedef enum logic [1:0] {
    SEL_OFF = 2'd0,
    SEL_R   = 2'd1,
    SEL_G   = 2'd2,
    SEL_B   = 2'd3
  } colour_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } track_state_e;

  // a dominates b and c by at least thr; 9 bits so b+thr never wraps
  function automatic logic dominant(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c, input logic [7:0] thr);
    logic [8:0] t;
    t = {1'b0, thr};
    return ({1'b0, a} >= ({1'b0, b} + t)) && ({1'b0, a} >= ({1'b0, c} + t));
  endfunction

  function automatic logic colour_match(input logic [1:0] sel, input logic [7:0] r,
                                        input logic [7:0] g, input logic [7:0] b,
                                        input logic [7:0] thr);
    logic m;
    m = 1'b0;
    case (sel)
      SEL_R:   m = dominant(r, g, b, thr);
      SEL_G:   m = dominant(g, r, b, thr);
      SEL_B:   m = dominant(b, r, g, thr);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/colour_centroid_tracker_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   start         : accepted only while idle; operands sampled on that edge
//   dividend      : W-bit numerator
//   divisor       : W-bit denominator (must be nonzero)
//   busy          : iterations in progress
//   done          : one-cycle pulse, quotient valid in that cycle
//   quotient      : W-bit result, held until the next start
// A division takes exactly W edges from start: the first iteration is
// folded into the start edge, so done is high W cycles after start.
module seq_divider
  import colour_track_pkg::*;
#(
  parameter int unsigned W = SUM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          accept, qbit;
  logic [W-1:0]  s_rem, s_quo, s_div;
  logic [W:0]    trial;

  assign accept = start && !busy_q;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    qbit   = 1'b0;
    // on accept the step works on the fresh operands instead of the registers
    s_rem  = accept ? '0       : rem_q;
    s_quo  = accept ? dividend : quo_q;
    s_div  = accept ? divisor  : div_q;
    trial  = {s_rem, s_quo[W-1]};
    if (accept || busy_q) begin
      rem_d = trial[W-1:0];
      if (trial >= {1'b0, s_div}) begin
        rem_d = W'(trial - {1'b0, s_div});
        qbit  = 1'b1;
      end
      quo_d = {s_quo[W-2:0], qbit};
    end
    if (accept) begin
      div_d  = divisor;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/colour_centroid_tracker.sv
// colour_centroid_tracker: flags pixels of a dominant colour and reports the
// per-frame centroid of the flagged pixels.
//   iCLK, iRST          : pixel clock, synchronous active-high reset
//   iValid, iX, iY      : pixel qualifier and coordinates
//   iRed/iGreen/iBlue   : pixel colour
//   iFrameEnd           : one-cycle end-of-frame pulse (same-cycle pixel counts)
//   iSel, iThr          : target colour (0 off, 1 R, 2 G, 3 B) and margin
//   oMask               : registered match flag, 1-cycle latency
//   oCX, oCY, oCount    : centroid and match count of last reported frame
//   oFound              : oCount nonzero
//   oValid              : one-cycle pulse when the report updates
//   oBusy               : division in progress (through the oValid cycle)
//   oDrop               : saturating count of frames ended while busy
module colour_centroid_tracker
  import colour_track_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACT_DEF,
  parameter int unsigned V_ACT = V_ACT_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  input  logic [15:0]      iX,
  input  logic [15:0]      iY,
  input  logic [7:0]       iRed,
  input  logic [7:0]       iGreen,
  input  logic [7:0]       iBlue,
  input  logic             iFrameEnd,
  input  logic [1:0]       iSel,
  input  logic [7:0]       iThr,
  output logic             oMask,
  output logic [9:0]       oCX,
  output logic [9:0]       oCY,
  output logic [CNT_W-1:0] oCount,
  output logic             oFound,
  output logic             oValid,
  output logic             oBusy,
  output logic [7:0]       oDrop
);
  track_state_e     state_q, state_d;
  logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] op_y_q, op_y_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [SUM_W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic             mask_q, mask_d, found_q, found_d, valid_q, valid_d;
  logic [9:0]       cx_q, cx_d, cy_q, cy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;

  logic             contrib, hit;
  logic [SUM_W-1:0] fin_x, fin_y;
  logic [CNT_W-1:0] fin_cnt;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend, div_divisor, div_quot;

  function automatic logic [9:0] sat10(input logic [SUM_W-1:0] q);
    return (|q[SUM_W-1:10]) ? 10'h3FF : q[9:0];
  endfunction

  assign contrib = iValid && (iX < 16'(H_ACT)) && (iY < 16'(V_ACT));
  assign hit     = contrib && colour_match(iSel, iRed, iGreen, iBlue, iThr);

  // frame totals including this cycle's pixel, so an iFrameEnd pixel counts
  always_comb begin
    fin_x   = sum_x_q + (hit ? SUM_W'(iX[9:0]) : '0);
    fin_y   = sum_y_q + (hit ? SUM_W'(iY[9:0]) : '0);
    fin_cnt = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // X division is fed straight from the live totals; Y uses the snapshot
  assign div_dividend = (state_q == ST_IDLE) ? fin_x : op_y_q;
  assign div_divisor  = SUM_W'((state_q == ST_IDLE) ? fin_cnt : op_cnt_q);
  assign div_start    = !div_busy &&
                        (((state_q == ST_IDLE) && iFrameEnd && (fin_cnt != '0)) ||
                         ((state_q == ST_DIV_X) && div_done));

  seq_divider #(.W(SUM_W)) u_div (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_d  = state_q;
    sum_x_d  = fin_x;
    sum_y_d  = fin_y;
    cnt_d    = fin_cnt;
    op_y_d   = op_y_q;
    op_cnt_d = op_cnt_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    mask_d   = hit;
    cx_d     = cx_q;
    cy_d     = cy_q;
    count_d  = count_q;
    found_d  = found_q;
    valid_d  = 1'b0;
    drop_d   = drop_q;

    if (iFrameEnd) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
      if ((state_q != ST_IDLE) && (drop_q != '1)) drop_d = drop_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iFrameEnd) begin
          op_y_d   = fin_y;
          op_cnt_d = fin_cnt;
          if (fin_cnt == '0) begin
            qx_d    = '0;
            qy_d    = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV_X;
          end
        end
      end
      ST_DIV_X: begin
        if (div_done) begin
          qx_d    = div_quot;
          state_d = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          qy_d    = div_quot;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cx_d    = sat10(qx_q);
        cy_d    = sat10(qy_q);
        count_d = op_cnt_q;
        found_d = (op_cnt_q != '0);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      cnt_q    <= '0;
      op_y_q   <= '0;
      op_cnt_q <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      mask_q   <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      count_q  <= '0;
      found_q  <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      cnt_q    <= cnt_d;
      op_y_q   <= op_y_d;
      op_cnt_q <= op_cnt_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      mask_q   <= mask_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      count_q  <= count_d;
      found_q  <= found_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign oMask  = mask_q;
  assign oCX    = cx_q;
  assign oCY    = cy_q;
  assign oCount = count_q;
  assign oFound = found_q;
  assign oValid = valid_q;
  // busy covers the oValid cycle as well
  assign oBusy  = (state_q != ST_IDLE) || valid_q;
  assign oDrop  = drop_q;

endmodule

// File: doc/colour_centroid_tracker.md
# colour_centroid_tracker

Per-pixel colour classifier and per-frame centroid tracker placed directly downstream of the D8M RGB reconstruction stage. It consumes the `sCCD_R/G/B` pixel stream together with the VGA pixel coordinates. Each pixel is flagged when it matches a selected dominant colour; coordinate sums and a match count accumulate over the frame. At end of frame a sequential divider turns the sums into a centroid (oCX, oCY) for overlay and LED/HEX reporting.

## Interface
Parameters:
- `H_ACT`, 640: active pixels per line; coordinates at or above this are ignored.
- `V_ACT`, 480: active lines per frame; coordinates at or above this are ignored.
- `SUM_W`, 28: width of coordinate-sum accumulators and of the divider.
- `CNT_W`, 19: width of the match counter.

Ports (one clock; reset is synchronous and active-high):
- `iCLK` in 1: pixel clock (`VGA_CLK_25M` domain).
- `iRST` in 1: synchronous active-high reset.
- `iValid` in 1: pixel qualifier (`READ_Request`).
- `iX` in 16: pixel column (`H_Cont`).
- `iY` in 16: pixel row (`V_Cont`).
- `iRed`, `iGreen`, `iBlue` in 8 each: pixel colour.
- `iFrameEnd` in 1: one-cycle pulse after the last active pixel of a frame.
- `iSel` in 2: target colour. 0 = off, 1 = red, 2 = green, 3 = blue.
- `iThr` in 8: dominance margin.
- `oMask` out 1: registered match flag for the pixel presented one cycle earlier.
- `oCX` out 10: centroid column.
- `oCY` out 10: centroid row.
- `oCount` out `CNT_W`: matched pixels in the last reported frame.
- `oFound` out 1: last reported frame had `oCount` > 0.
- `oValid` out 1: one-cycle pulse when `oCX`, `oCY`, `oCount` and `oFound` update.
- `oBusy` out 1: divider active.
- `oDrop` out 8: saturating count of frames dropped because the divider was busy.

## Operation
- Match rule, evaluated with 9-bit arithmetic:
  - Red: `R >= G+iThr` and `R >= B+iThr`.
  - Green and blue: the same rule, permuted.
  - `iSel` = 0: no pixel matches.
- A pixel contributes only when `iValid`, `iX < H_ACT` and `iY < V_ACT` all hold.
- On a contributing match: `sumX += iX[9:0]`, `sumY += iY[9:0]`, `cnt += 1`. `cnt` saturates at all-ones; the sums cannot overflow at the default sizes.
- `oMask` = match AND contributing, registered.
- Cycle with `iFrameEnd`:
  - A pixel in the same cycle is counted into the ending frame.
  - The final sums are snapshotted into divider operands.
  - Accumulators clear to 0 and the next cycle's pixel starts a fresh frame.
- FSM states: IDLE, DIV_X, DIV_Y, DONE.
  - IDLE with `iFrameEnd`:
    - If cnt_final = 0, go to DONE with quotients forced to 0.
    - Otherwise go to DIV_X.
  - DIV_X: `SUM_W` restoring iterations computing `sumX / cnt`, then go to DIV_Y.
  - DIV_Y: `SUM_W` iterations computing `sumY / cnt`, then go to DONE.
  - DONE: register the outputs, pulse `oValid`, go to IDLE.
- Quotients saturate to 10 bits: any upper bit set gives 1023, which cannot occur with legal inputs.
- `iFrameEnd` while not IDLE:
  - The accumulators still clear.
  - The snapshot is discarded and the division in progress completes unaffected.
  - `oDrop` increments, saturating at 255.
- `iSel` and `iThr` are sampled every pixel. Changing them mid-frame is legal and produces a mixed frame.

## Timing
- `oMask` latency: 1 cycle.
- Let `iFrameEnd` be sampled at edge T.
  - Nonzero count: `oValid` is high in cycle T+2·`SUM_W`+2, i.e. T+58 at the default `SUM_W` of 28.
  - Zero count: `oValid` is high in cycle T+2.
- `oBusy` is high from T+1 until the cycle `oValid` rises, inclusive.
- `oCX`, `oCY`, `oCount` and `oFound` hold their values between `oValid` pulses.
- Reset values:
  - All outputs are 0; `oMask` = 0 and `oValid` = 0.
  - Accumulators are 0, FSM is IDLE, `oDrop` = 0.
- Reset mid-division aborts it: no `oValid` is produced and the outputs return to 0.

## Structure
- Package `colour_track_pkg` holds:
  - Colour-select constants `SEL_OFF`, `SEL_R`, `SEL_G`, `SEL_B`.
  - FSM state typedef.
  - Default widths.
- Sub-module `seq_divider`:
  - Unsigned restoring divider, one bit per cycle.
  - Handshake: `start`/`done`, with `start` accepted only when idle.
  - Instantiated once and reused for X then Y.

## Test plan
- Reset, then a frame of all-black pixels with `iSel`=1 and `iFrameEnd` → `oValid` at T+2, `oFound`=0, `oCount`=0, `oCX`=`oCY`=0.
- Pure red (255,0,0) 10×10 square at x=100..109, y=50..59, `iThr`=40 → `oCount`=100, `oCX`=104, `oCY`=54, `oValid` at T+58, `oMask`=1 exactly on those pixels.
- Pixel (120,100,0) with `iThr`=40 → no match. The same pixel with `iThr`=20 → match. Pixel (255,215,0) with `iThr`=40 → match (boundary, equality passes).
- Second `iFrameEnd` 20 cycles after the first → `oDrop`=1; the first result is reported unchanged; the next frame's accumulators start from 0.
- Matched pixels at `iX`=640 or `iY`=480, and a matched pixel with `iValid`=0 → none counted, `oMask`=0.
- `iRST` asserted at T+30 of a division → no `oValid`; outputs 0 next cycle; the next frame is processed normally.
